led_share_sched: RTL
====================

Name: led_share_sched

Overview:
Schedules a single board LED among NUM_REQ requesters. Each requester asks for an N-blink pattern. The block grants requesters round-robin, plays the granted pattern (fixed ON/OFF periods), then holds the LED dark for a separation gap. Completion is reported with a one-cycle done pulse. It sits between status/diagnostic logic and the top-level LED pin, replacing free-running counter blink.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of per-requester blink count
ON_CYCLES, 31250000, LED-on cycles per blink (0.25 s @125 MHz), >=1
OFF_CYCLES, 31250000, LED-off cycles between blinks, >=1
GAP_CYCLES, 125000000, dark cycles after a pattern before done (1 s), >=1
TMR_W, 32, timer width; must hold max(ON,OFF,GAP)-1

Ports:
clk_i  in  1  system clock (125 MHz nominal)
rst_i  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  level request per requester; hold until done or abort
count_i  in  NUM_REQ*CNT_W  blink count, requester k at [k*CNT_W +: CNT_W]; sampled only at grant
grant_o  out  NUM_REQ  one-hot current owner; zero when idle
done_o  out  NUM_REQ  one-cycle pulse to owner on normal completion
busy_o  out  1  high whenever grant_o != 0
led_o  out  1  LED drive, registered

Behaviour:
- One clock. Reset is synchronous and active-high; ports are clk_i / rst_i.
- All outputs are registered. Reset values: led_o=0, grant_o=0, done_o=0, busy_o=0. State=IDLE, timer=0, remaining=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE with any req_i set:
  - Pick the first set bit searching last+1, last+2, ... (wrap mod NUM_REQ).
  - At the next edge: grant_o=onehot(k), busy_o=1, last=k, remaining=count_i[k].
  - If count!=0: state=ON, led_o=1, timer=ON_CYCLES-1.
  - If count==0: state=GAP, led_o=0, timer=GAP_CYCLES-1.
- IDLE with no request: outputs hold at their idle values.
- ON: led_o=1 for exactly ON_CYCLES cycles. On the timer==0 cycle: state=OFF, timer=OFF_CYCLES-1, remaining-=1.
- OFF: led_o=0 for exactly OFF_CYCLES cycles. On the timer==0 cycle: if remaining==0, go to GAP with timer=GAP_CYCLES-1; else go to ON with timer=ON_CYCLES-1.
- GAP: led_o=0 for exactly GAP_CYCLES cycles. On the timer==0 cycle, at the next edge: done_o[k]=1 for one cycle, grant_o=0, busy_o=0, state=IDLE.
- Minimum turnaround: the done cycle is spent in IDLE. The next grant can appear at the edge after the done pulse, even if the same requester still holds req_i.
- Abort: if req_i[k] of the owner is low during ON or OFF, the next edge goes to GAP (led_o=0, full GAP), and no done_o pulse is issued on completion. A drop during GAP has no effect, and done_o is still pulsed.
- Non-owner req_i and count_i changes during a pattern are ignored until IDLE. A count_i change by the owner after grant is ignored.
- Latency from req_i rising (IDLE) to led_o high: 1 edge.
- Total owned time for count c>=1: c*ON_CYCLES + c*OFF_CYCLES + GAP_CYCLES cycles, then the done cycle.
- Arithmetic: timer is a down-counter, no wrap (reloaded at 0). remaining is CNT_W bits, decremented only in ON, and never below 0.
- Reset mid-pattern: at the next edge all outputs return to reset values. No done pulse; pointer returns to NUM_REQ-1.

Decomposition:
- Shared package/header ledblink_pkg:
  - FSM state encoding (IDLE=0, ON=1, OFF=2, GAP=3).
  - Default timing constants ON_CYCLES/OFF_CYCLES/GAP_CYCLES for 125 MHz.
  - CLK_HZ=125000000.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Parameters: NUM_REQ.
  - Inputs: req, last.
  - Outputs: valid, onehot grant, index.
  - Reused by later shared-resource blocks.
- FSM, timer and counters stay in led_share_sched.

Test Plan:
Bench uses NUM_REQ=4, ON=3, OFF=2, GAP=4.
- Reset, then req_i=0001, count0=2 -> grant_o=0001 and led_o=1 at edge 1. led_o pattern: 1,1,1,0,0,1,1,1,0,0,0,0,0,0 (14 cycles). done_o=0001 on cycle 15, grant_o=0 the same cycle.
- req_i=1111 held, all counts=1 -> grant order 0,1,2,3,0. Each ownership lasts 9 cycles plus 1 done/idle cycle.
- count=0 for requester 2, req_i=0100 -> led_o stays 0. GAP of 4 cycles, then done_o=0100.
- Owner drops req_i during the 2nd ON of a count=3 pattern -> led_o=0 at the next edge. 4 GAP cycles follow, done_o stays 0 throughout, then IDLE.
- rst_i=1 mid-OFF with requester 1 granted -> next edge: led_o=0, grant_o=0, busy_o=0, done_o=0. After release with req_i=0011, requester 0 is granted first.
- count=15 (CNT_W max) -> exactly 15 ON pulses of 3 cycles each, no wrap, then done.

Source files
------------

// File: rtl/ledblink_pkg.sv
// Shared constants for the board LED blink blocks: FSM state encoding
// and default timing for a 125 MHz system clock.
package ledblink_pkg;

    localparam int CLK_HZ = 125000000;

    // Default timing: 0.25 s on, 0.25 s off, 1 s separation gap.
    localparam int DEF_ON_CYCLES  = 31250000;
    localparam int DEF_OFF_CYCLES = 31250000;
    localparam int DEF_GAP_CYCLES = 125000000;

    // Scheduler FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns the first set request bit
// found searching last+1, last+2, ... with wrap modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Search starting just after the previous winner; first hit wins.
    always_comb begin
        valid    = 1'b0;
        grant    = '0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid           = 1'b1;
                index           = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_share_sched.sv
// Shares one board LED among NUM_REQ requesters. The granted requester's
// N-blink pattern is played (ON/OFF periods), followed by a dark gap,
// then a one-cycle done pulse to the owner.
//
// Handshake: req_i[k] is a level request held by requester k. The block
// answers with grant_o[k] for the whole ownership; on normal completion it
// pulses done_o[k] for one cycle (grant_o already low in that cycle). If the
// owner drops req_i[k] while its pattern is playing, the block aborts into a
// full dark gap and releases the grant without a done pulse. count_i[k] is
// sampled only on the grant edge.
module led_share_sched
    import ledblink_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 4,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TMR_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] count_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic                     led_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;
    logic               abort_q, abort_d;

    logic               arb_valid;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [CNT_W-1:0]   cnt_pick;
    logic               owner_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_i),
        .last  (last_q),
        .valid (arb_valid),
        .grant (arb_grant),
        .index (arb_idx)
    );

    assign cnt_pick  = count_i[arb_idx*CNT_W +: CNT_W];
    // The owner still wants the LED when its request bit is high.
    assign owner_req = |(req_i & grant_q);

    // Next-state logic for the grant / blink / gap sequence.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        led_d   = led_q;
        abort_d = abort_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    busy_d  = 1'b1;
                    last_d  = arb_idx;
                    rem_d   = cnt_pick;
                    abort_d = 1'b0;
                    if (cnt_pick != '0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                        timer_d = ON_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        led_d   = 1'b0;
                        timer_d = GAP_LOAD;
                    end
                end
            end

            ST_ON: begin
                if (!owner_req) begin
                    state_d = ST_GAP;
                    led_d   = 1'b0;
                    timer_d = GAP_LOAD;
                    abort_d = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                    timer_d = OFF_LOAD;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_OFF: begin
                if (!owner_req) begin
                    state_d = ST_GAP;
                    led_d   = 1'b0;
                    timer_d = GAP_LOAD;
                    abort_d = 1'b1;
                end else if (timer_q == '0) begin
                    if (rem_q == '0) begin
                        state_d = ST_GAP;
                        led_d   = 1'b0;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                        timer_d = ON_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin // ST_GAP: requests are ignored here
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                    done_d  = abort_q ? '0 : grant_q;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
            abort_q <= abort_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign led_o   = led_q;

endmodule
